// File: rtl/amo_rmw_sequencer.sv
// Atomic read-modify-write sequencer: reads the old word, feeds it to the AMO ALU,
// writes back the ALU result and returns the old word with the request tag.
module amo_rmw_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DATAW      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATAW-1:0]      req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATAW-1:0]      mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [DATAW-1:0]      mem_rsp_data,
  output logic [4:0]            alu_op,
  output logic [DATAW-1:0]      alu_in1,
  output logic [DATAW-1:0]      alu_in2,
  input  logic [DATAW-1:0]      alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATAW-1:0]      rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ALU_EXEC,
    ALU_CAP,
    WR_REQ,
    RSP
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATAW-1:0]      rs2_q, rs2_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATAW-1:0]      old_q, old_d;
  logic [DATAW-1:0]      new_q, new_d;
  logic [4:0]            alu_op_q, alu_op_d;
  logic [DATAW-1:0]      alu_in1_q, alu_in1_d;
  logic [DATAW-1:0]      alu_in2_q, alu_in2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      tag_q     <= '0;
      old_q     <= '0;
      new_q     <= '0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      rs2_q     <= rs2_d;
      tag_q     <= tag_d;
      old_q     <= old_d;
      new_q     <= new_d;
      alu_op_q  <= alu_op_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    rs2_d     = rs2_q;
    tag_d     = tag_q;
    old_d     = old_q;
    new_d     = new_q;
    alu_op_d  = alu_op_q;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          rs2_d   = req_data;
          tag_d   = req_tag;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // ALU operands are loaded here so they are already stable during ALU_EXEC.
        if (mem_rsp_valid) begin
          old_d     = mem_rsp_data;
          alu_in1_d = mem_rsp_data;
          alu_in2_d = rs2_q;
          alu_op_d  = op_q;
          state_d   = ALU_EXEC;
        end
      end
      ALU_EXEC: state_d = ALU_CAP;
      ALU_CAP: begin
        new_d   = alu_result;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_req_ready) state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_req_rw    = (state_q == WR_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = new_q;
  assign alu_op        = alu_op_q;
  assign alu_in1       = alu_in1_q;
  assign alu_in2       = alu_in2_q;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_data      = old_q;
  assign rsp_tag       = tag_q;

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// Bench for amo_rmw_sequencer: memory and AMO ALU models, transaction-level
// scoreboard checked every cycle, plus directed scenarios with literal expectations.
module tb_amo_rmw_sequencer;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SWAP = 5'h01;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h08;
  localparam logic [4:0] OP_AND  = 5'h0C;
  localparam logic [4:0] OP_MIN  = 5'h10;
  localparam logic [4:0] OP_MAX  = 5'h14;
  localparam logic [4:0] OP_MINU = 5'h18;
  localparam logic [4:0] OP_MAXU = 5'h1C;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic [7:0]  req_tag;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        busy;

  logic        env_v = 1'b0, stray_v = 1'b0;
  logic [31:0] env_d = '0, stray_d = '0;
  assign mem_rsp_valid = env_v | stray_v;
  assign mem_rsp_data  = env_v ? env_d : stray_d;

  always #5 clk = ~clk;

  amo_rmw_sequencer #(.ADDR_WIDTH(32), .TAG_WIDTH(8), .DATAW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  int unsigned nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] amo(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SWAP: return b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      OP_MINU: return (a < b) ? a : b;
      OP_MAXU: return (a > b) ? a : b;
      default: return '0;
    endcase
  endfunction

  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Environment: memory answers a read the cycle after its handshake; the ALU
  // presents f(inputs) one cycle after those inputs were shown.
  logic        rp = 1'b0;
  logic [31:0] rd = '0, alu_next = '0;
  initial begin : env
    alu_result = '0;
    forever begin
      @(negedge clk);
      env_v      = rp;
      env_d      = rd;
      alu_result = alu_next;
      #2;
      rp       = !reset && mem_req_valid && mem_req_ready && !mem_req_rw;
      rd       = mrd(mem_req_addr);
      alu_next = amo(alu_op, alu_in1, alu_in2);
    end
  end

  // Scoreboard state: one transaction in flight at most.
  bit          inflight = 0, rd_done = 0, wr_done = 0, alu_live = 0, rsp_seen = 0, rst_seen = 0;
  logic [4:0]  cur_op = '0;
  logic [31:0] cur_addr = '0, cur_rs2 = '0, exp_old = '0, exp_new = '0;
  logic [7:0]  cur_tag = '0;
  int unsigned lat = 0, rsp_lat = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  bit          pm_stall = 0, pr_stall = 0;
  logic        pm_rw = 1'b0;
  logic [31:0] pm_addr = '0, pm_data = '0, pr_data = '0;
  logic [7:0]  pr_tag = '0;
  logic [31:0] wr_log[$], rsp_log[$];
  logic [7:0]  tag_log[$];
  int unsigned acc_cyc[$], rsp_cyc[$];

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst_seen) begin
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_mem_addr", mem_req_addr, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_tag", {24'b0, rsp_tag}, 32'd0);
        rst_seen = 0;
      end
      if (reset) begin
        inflight = 0; rd_done = 0; wr_done = 0; alu_live = 0; rsp_seen = 0;
        pm_stall = 0; pr_stall = 0; rst_seen = 1;
      end else begin
        if (inflight && !rsp_seen) lat++;
        chk("busy", {31'b0, busy}, {31'b0, inflight});
        chk("req_ready", {31'b0, req_ready}, {31'b0, !inflight});
        if (pm_stall) begin
          chk("hold_mem_valid", {31'b0, mem_req_valid}, 32'd1);
          chk("hold_mem_rw", {31'b0, mem_req_rw}, {31'b0, pm_rw});
          chk("hold_mem_addr", mem_req_addr, pm_addr);
          if (pm_rw) chk("hold_mem_data", mem_req_data, pm_data);
        end
        if (pr_stall) begin
          chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
          chk("hold_rsp_data", rsp_data, pr_data);
          chk("hold_rsp_tag", {24'b0, rsp_tag}, {24'b0, pr_tag});
        end
        if (mem_req_valid) begin
          if (!inflight) chk("mem_req_when_idle", {31'b0, mem_req_valid}, 32'd0);
          else if (!mem_req_rw) begin
            chk("rd_order", {31'b0, rd_done}, 32'd0);
            chk("rd_addr", mem_req_addr, cur_addr);
          end else begin
            chk("wr_order", {30'b0, rd_done, wr_done}, 32'd2);
            chk("wr_addr", mem_req_addr, cur_addr);
            chk("wr_data", mem_req_data, exp_new);
          end
        end
        if (alu_live) begin
          chk("alu_op", {27'b0, alu_op}, {27'b0, cur_op});
          chk("alu_in1", alu_in1, exp_old);
          chk("alu_in2", alu_in2, cur_rs2);
        end
        if (rsp_valid) begin
          if (!inflight) chk("rsp_when_idle", {31'b0, rsp_valid}, 32'd0);
          else begin
            chk("rsp_after_write", {31'b0, wr_done}, 32'd1);
            chk("rsp_data", rsp_data, exp_old);
            chk("rsp_tag", {24'b0, rsp_tag}, {24'b0, cur_tag});
            if (!rsp_seen) begin rsp_seen = 1; rsp_lat = lat; end
          end
        end
        if (inflight && rd_done && !wr_done && !alu_live && mem_rsp_valid) alu_live = 1;
        pm_stall = mem_req_valid && !mem_req_ready;
        pm_rw = mem_req_rw; pm_addr = mem_req_addr; pm_data = mem_req_data;
        pr_stall = rsp_valid && !rsp_ready;
        pr_data = rsp_data; pr_tag = rsp_tag;
        if (inflight && mem_req_valid && mem_req_ready) begin
          if (!mem_req_rw) begin
            rd_done = 1; rd_cnt++;
            exp_old = mrd(cur_addr);
            exp_new = amo(cur_op, exp_old, cur_rs2);
          end else begin
            wr_done = 1; wr_cnt++;
            mem[cur_addr] = exp_new;
            wr_log.push_back(mem_req_data);
          end
        end
        if (inflight && rsp_valid && rsp_ready) begin
          inflight = 0; alu_live = 0;
          rsp_log.push_back(rsp_data); tag_log.push_back(rsp_tag); rsp_cyc.push_back(cyc);
        end
        if (req_valid && req_ready) begin
          inflight = 1; rd_done = 0; wr_done = 0; alu_live = 0; rsp_seen = 0; lat = 0;
          cur_op = req_op; cur_addr = req_addr; cur_rs2 = req_data; cur_tag = req_tag;
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] t);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_tag = t;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!inflight) return;
      @(negedge clk);
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_mem(input logic rw);
    for (int i = 0; i < 300; i++) begin
      if (mem_req_valid && mem_req_rw == rw) return;
      @(negedge clk);
    end
    chk("mem_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) return;
      @(negedge clk);
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] t);
    issue(op, a, d, t);
    wait_idle();
  endtask

  int unsigned rd0, wr0, na, nr;

  initial begin : stim
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; req_tag = '0;
    mem_req_ready = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD with nominal memory timing
    mem[32'h100] = 32'd5;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(OP_ADD, 32'h100, 32'd3, 8'h2A);
    chk("add_reads", rd_cnt - rd0, 32'd1);
    chk("add_writes", wr_cnt - wr0, 32'd1);
    chk("add_wdata", wr_log[$], 32'd8);
    chk("add_rsp", rsp_log[$], 32'd5);
    chk("add_tag", {24'b0, tag_log[$]}, 32'h2A);
    chk("add_latency", rsp_lat, 32'd6);
    chk("add_model_mem", mem[32'h100], 32'd8);

    // signed vs unsigned compares
    mem[32'h200] = 32'hFFFF_FFFF;
    run_op(OP_MIN, 32'h200, 32'd1, 8'h01);
    chk("min_wdata", wr_log[$], 32'hFFFF_FFFF);
    chk("min_rsp", rsp_log[$], 32'hFFFF_FFFF);
    mem[32'h200] = 32'hFFFF_FFFF;
    run_op(OP_MINU, 32'h200, 32'd1, 8'h02);
    chk("minu_wdata", wr_log[$], 32'd1);
    chk("minu_rsp", rsp_log[$], 32'hFFFF_FFFF);
    mem[32'h200] = 32'hFFFF_FFFF;
    run_op(OP_MAXU, 32'h200, 32'd1, 8'h03);
    chk("maxu_wdata", wr_log[$], 32'hFFFF_FFFF);
    chk("maxu_rsp", rsp_log[$], 32'hFFFF_FFFF);

    // stray response in IDLE, then backpressure on read, write and response
    mem[32'h300] = 32'h10;
    stray_v = 1'b1; stray_d = 32'hBAD0_BAD0;
    @(negedge clk);
    stray_v = 1'b0;
    mem_req_ready = 1'b0; rsp_ready = 1'b0;
    issue(OP_OR, 32'h300, 32'h0F, 8'h33);
    wait_mem(1'b0);
    repeat (4) @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    wait_mem(1'b1);
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b1;
    wait_rsp();
    repeat (3) @(negedge clk);
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_wdata", wr_log[$], 32'h1F);
    chk("bp_rsp", rsp_log[$], 32'h10);
    chk("bp_tag", {24'b0, tag_log[$]}, 32'h33);

    // reset while in ALU_CAP aborts with no write
    mem[32'h400] = 32'h77;
    wr0 = wr_cnt;
    issue(OP_ADD, 32'h400, 32'd1, 8'h44);
    repeat (3) @(negedge clk);
    chk("cap_busy", {31'b0, busy}, 32'd1);
    chk("cap_no_mem_req", {31'b0, mem_req_valid}, 32'd0);
    chk("cap_alu_in1", alu_in1, 32'h77);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_write", wr_cnt - wr0, 32'd0);
    run_op(OP_ADD, 32'h400, 32'd1, 8'h45);
    chk("after_abort_rsp", rsp_log[$], 32'h77);
    chk("after_abort_wdata", wr_log[$], 32'h78);

    // back-to-back requests to one address
    mem[32'h500] = 32'h1234;
    issue(OP_SWAP, 32'h500, 32'hDEAD, 8'h51);
    issue(OP_XOR, 32'h500, 32'hFFFF, 8'h52);
    wait_idle();
    chk("b2b_wdata1", wr_log[wr_log.size()-2], 32'hDEAD);
    chk("b2b_rsp1", rsp_log[rsp_log.size()-2], 32'h1234);
    chk("b2b_wdata2", wr_log[$], 32'h2152);
    chk("b2b_rsp2", rsp_log[$], 32'hDEAD);
    chk("b2b_tag2", {24'b0, tag_log[$]}, 32'h52);
    na = acc_cyc[$];
    nr = rsp_cyc[rsp_cyc.size()-2];
    chk("b2b_accept_cycle", na, nr + 1);

    // unknown opcode writes 0; identical SWAP still writes
    mem[32'h600] = 32'hABCD;
    run_op(5'h1F, 32'h600, 32'h55, 8'h61);
    chk("unk_wdata", wr_log[$], 32'd0);
    chk("unk_rsp", rsp_log[$], 32'hABCD);
    wr0 = wr_cnt;
    run_op(OP_SWAP, 32'h600, 32'd0, 8'h62);
    chk("same_swap_writes", wr_cnt - wr0, 32'd1);
    chk("same_swap_rsp", rsp_log[$], 32'd0);
    mem[32'h700] = 32'h8000_0000;
    run_op(OP_MAX, 32'h700, 32'd7, 8'h71);
    chk("max_wdata", wr_log[$], 32'd7);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/amo_rmw_sequencer.md
Name: amo_rmw_sequencer

Overview:
- Atomic read-modify-write controller that drives the AMO ALU unit.
- Accepts one AMO request at a time from the LSU and reads the old word from memory.
- Presents the old word and the rs2 operand to the AMO ALU, captures the ALU's registered result, and writes it back.
- Returns the old word to the writeback path with the request tag.

Parameters:
ADDR_WIDTH, 32, byte address width of request and memory ports
TAG_WIDTH, 8, width of request/response tag passed through unchanged
DATAW, 32, data width; only 32 is supported

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  AMO request valid
req_ready  out  1  sequencer can accept a request
req_op  in  5  AMO opcode (`INST_AMO_* encoding)
req_addr  in  ADDR_WIDTH  word-aligned target address
req_data  in  DATAW  rs2 operand
req_tag  in  TAG_WIDTH  request tag
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  0=read, 1=write
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_data  out  DATAW  write data
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  DATAW  read data
alu_op  out  5  opcode to AMO ALU
alu_in1  out  DATAW  old memory word to ALU
alu_in2  out  DATAW  rs2 to ALU
alu_result  in  DATAW  ALU result, registered one cycle after inputs
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATAW  old memory word (rd value)
rsp_tag  out  TAG_WIDTH  tag of completed request
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: synchronous, active-high, clock clk; FSM returns to IDLE.
- Output values during and after reset:
  - req_ready=1 after reset releases.
  - mem_req_valid=0, rsp_valid=0, busy=0.
  - All data/address/tag registers cleared to 0.
  - alu_op=0.
- Reset mid-operation aborts immediately; no write is issued after the reset cycle.
- States: IDLE, RD_REQ, RD_WAIT, ALU_EXEC, ALU_CAP, WR_REQ, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/addr/data/tag, then go to RD_REQ.
- RD_REQ:
  - Drive mem_req_valid=1, rw=0, addr=latched addr.
  - Hold valid and all fields stable until mem_req_ready.
  - On handshake go to RD_WAIT.
- RD_WAIT:
  - On mem_rsp_valid: latch mem_rsp_data as old, then go to ALU_EXEC.
  - mem_rsp_valid is ignored in all other states.
- ALU_EXEC:
  - alu_in1=old, alu_in2=latched rs2, alu_op=latched op.
  - These ALU outputs are registered and stay stable from ALU_EXEC until IDLE.
  - Go to ALU_CAP.
- ALU_CAP:
  - Latch alu_result as new; this is exactly one cycle after ALU_EXEC.
  - Go to WR_REQ.
- WR_REQ:
  - Drive mem_req_valid=1, rw=1, addr=latched addr, data=new.
  - Hold valid and fields until mem_req_ready; writes are posted (no response expected).
  - On handshake go to RSP.
- RSP:
  - rsp_valid=1, rsp_data=old, rsp_tag=latched tag.
  - Hold until rsp_ready, then go to IDLE.
- Timing:
  - req_ready is low in all states except IDLE.
  - No back-to-back acceptance: the next request can be accepted in the cycle after the RSP handshake.
- Latency: with memory ready and read data returned the cycle after the read handshake, the accept-to-rsp_valid latency is 6 cycles.
- Memory write always occurs for every op, including when new equals old, e.g. SWAP of an identical value or MIN with no change.
- Unknown req_op is passed through; the ALU yields 0, and 0 is written.
- rsp_data is always the pre-modification word, never the ALU result.

Test Plan:
- ADD: mem[0x100]=5, rs2=3, tag=0x2A -> one read of 0x100, then one write of 8 to 0x100, then rsp_data=5, rsp_tag=0x2A.
- Signed vs unsigned compare: mem=0xFFFFFFFF, rs2=1:
  - MIN -> write 0xFFFFFFFF.
  - MINU -> write 1.
  - MAXU -> write 0xFFFFFFFF.
  - rsp_data=0xFFFFFFFF in all cases.
- Backpressure:
  - Hold mem_req_ready=0 for 4 cycles in RD_REQ and again in WR_REQ -> valid, rw, addr and data stay stable throughout.
  - Hold rsp_ready=0 for 3 cycles -> rsp fields stable; req_ready=0 throughout.
- Stray memory responses: mem_rsp_valid pulsed during IDLE and during WR_REQ -> ignored; later data is unaffected.
- Reset mid-op: assert reset in ALU_CAP -> next cycle IDLE, req_ready=1, busy=0, and no write handshake ever appears for that request.
- Back-to-back: two queued requests (SWAP 0xDEAD, then XOR 0xFFFF to the same address holding 0x1234):
  - First completes with write 0xDEAD, rsp 0x1234.
  - Second completes with write 0xDEAD^0xFFFF=0x2152, rsp 0xDEAD.
  - Second request is accepted only after the first RSP handshake.
